// File: rtl/ysyx_23060061_rf_pkg.sv
// Shared constants for the scoreboarded integer register file.
package ysyx_23060061_rf_pkg;

    localparam int unsigned RF_ADDR_WIDTH = 5;
    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned RF_X0_IDX     = 0;
    localparam int unsigned RF_MAX_RPORTS = 4;

endpackage : ysyx_23060061_rf_pkg

// File: rtl/ysyx_23060061_busy_table.sv
// Busy-bit scoreboard: tracks registers with an outstanding writer.
// Allocation sets, writeback clears, flush wipes everything.
module ysyx_23060061_busy_table
    import ysyx_23060061_rf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           alloc_valid,
    input  logic [ADDR_WIDTH-1:0]          alloc_addr,
    output logic                           alloc_ready,
    input  logic                           clr_valid,
    input  logic [ADDR_WIDTH-1:0]          clr_addr,
    input  logic                           flush,
    output logic [(1 << ADDR_WIDTH)-1:0]   busy,
    output logic [ADDR_WIDTH:0]            busy_count,
    output logic                           idle
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(RF_X0_IDX);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [CW-1:0]    count_q, count_d;
    logic             idle_q, idle_d;
    logic             set_c, clr_c;

    // Ready depends on registered busy state only, never on a same-cycle writeback.
    assign alloc_ready = !flush && ((alloc_addr == X0) || !busy_q[alloc_addr]);

    // Next busy vector and population count.
    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        set_c   = alloc_valid && alloc_ready && (alloc_addr != X0);
        clr_c   = clr_valid && (clr_addr != X0) && busy_q[clr_addr];
        if (clr_c) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_c) begin
            busy_d[alloc_addr] = 1'b1;
        end
        if (set_c && !clr_c) begin
            count_d = count_q + CW'(1);
        end else if (clr_c && !set_c) begin
            count_d = count_q - CW'(1);
        end
        if (flush) begin
            busy_d  = '0;
            count_d = '0;
        end
        idle_d = (count_d == '0);
    end

    // Scoreboard state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            count_q <= '0;
            idle_q  <= 1'b1;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            idle_q  <= idle_d;
        end
    end

    assign busy       = busy_q;
    assign busy_count = count_q;
    assign idle       = idle_q;

endmodule : ysyx_23060061_busy_table

// File: rtl/ysyx_23060061_scoreboard_regfile.sv
// Multi-read-port register file with integrated busy-bit scoreboard.
// x0 reads zero and is never written.
// Optional feature: define SCOREBOARD_RF_BYPASS_EN for write-through reads
// (same-cycle writeback data and cleared busy flag seen on matching ports).
module ysyx_23060061_scoreboard_regfile
    import ysyx_23060061_rf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned NR_RPORTS  = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wen,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic                             alloc_valid,
    input  logic [ADDR_WIDTH-1:0]            alloc_addr,
    output logic                             alloc_ready,
    input  logic                             flush,
    input  logic [NR_RPORTS*ADDR_WIDTH-1:0]  raddr,
    output logic [NR_RPORTS*DATA_WIDTH-1:0]  rdata,
    output logic [NR_RPORTS-1:0]             rbusy,
    output logic [ADDR_WIDTH:0]              busy_count,
    output logic                             idle
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(RF_X0_IDX);

    logic [DATA_WIDTH-1:0] rf_q [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [ADDR_WIDTH-1:0] ra_c;

    ysyx_23060061_busy_table #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_busy_table (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .alloc_ready (alloc_ready),
        .clr_valid   (wen),
        .clr_addr    (waddr),
        .flush       (flush),
        .busy        (busy),
        .busy_count  (busy_count),
        .idle        (idle)
    );

    // Data array; writes land regardless of busy state or flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wen && (waddr != X0)) begin
            rf_q[waddr] <= wdata;
        end
    end

    // Combinational read muxes with optional write-through bypass.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra_c  = '0;
        for (int unsigned p = 0; p < NR_RPORTS; p++) begin
            ra_c = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
            if (ra_c != X0) begin
                rdata[p*DATA_WIDTH +: DATA_WIDTH] = rf_q[ra_c];
                rbusy[p]                          = busy[ra_c];
`ifdef SCOREBOARD_RF_BYPASS_EN
                if (wen && (waddr == ra_c)) begin
                    rdata[p*DATA_WIDTH +: DATA_WIDTH] = wdata;
                    rbusy[p]                          = 1'b0;
                end
`endif
            end
        end
    end

endmodule : ysyx_23060061_scoreboard_regfile

// File: tb/tb_ysyx_23060061_scoreboard_regfile.sv
// Directed self-checking bench for the scoreboarded register file.
module tb_ysyx_23060061_scoreboard_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        alloc_valid;
    logic [4:0]  alloc_addr;
    logic        alloc_ready;
    logic        flush;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic [5:0]  busy_count;
    logic        idle;

    int checks   = 0;
    int failures = 0;

    ysyx_23060061_scoreboard_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .wen         (wen),
        .waddr       (waddr),
        .wdata       (wdata),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .alloc_ready (alloc_ready),
        .flush       (flush),
        .raddr       (raddr),
        .rdata       (rdata),
        .rbusy       (rbusy),
        .busy_count  (busy_count),
        .idle        (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_raddr(input logic [4:0] p0, input logic [4:0] p1);
        raddr = {p1, p0};
        #1;
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
        alloc_valid = 1'b0; alloc_addr = '0; flush = 1'b0; raddr = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state across all indices on both ports
        for (int i = 0; i < 32; i++) begin
            set_raddr(5'(i), 5'(31 - i));
            chk("rst_rdata0", 64'(rdata[31:0]), 64'd0);
            chk("rst_rdata1", 64'(rdata[63:32]), 64'd0);
            chk("rst_rbusy", 64'(rbusy), 64'd0);
        end
        chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_busy_count", 64'(busy_count), 64'd0);

        // Write x5 and attempt x0
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        tick();
        waddr = 5'd0; wdata = 32'h1234;
        tick();
        wen = 1'b0;
        set_raddr(5'd5, 5'd0);
        chk("wr_x5", 64'(rdata[31:0]), 64'hDEADBEEF);
        chk("wr_x0", 64'(rdata[63:32]), 64'd0);
        chk("wr_nobusy_count", 64'(busy_count), 64'd0);

        // Allocate x7
        alloc_valid = 1'b1; alloc_addr = 5'd7;
        #1;
        chk("alloc7_ready", 64'(alloc_ready), 64'd1);
        tick();
        alloc_valid = 1'b0;
        set_raddr(5'd7, 5'd5);
        chk("alloc7_rbusy", 64'(rbusy[0]), 64'd1);
        chk("alloc7_rbusy_other", 64'(rbusy[1]), 64'd0);
        chk("alloc7_count", 64'(busy_count), 64'd1);
        chk("alloc7_idle", 64'(idle), 64'd0);

        // Re-alloc x7 while writeback to x7 in the same cycle: not ready
        alloc_valid = 1'b1; alloc_addr = 5'd7;
        wen = 1'b1; waddr = 5'd7; wdata = 32'h55;
        #1;
        chk("realloc7_ready", 64'(alloc_ready), 64'd0);
        tick();
        alloc_valid = 1'b0; wen = 1'b0;
        #1;
        chk("wb7_rbusy", 64'(rbusy[0]), 64'd0);
        chk("wb7_count", 64'(busy_count), 64'd0);
        chk("wb7_data", 64'(rdata[31:0]), 64'h55);
        chk("wb7_idle", 64'(idle), 64'd1);

        // Allocate x3, then writeback x3 while reading it
        alloc_valid = 1'b1; alloc_addr = 5'd3;
        tick();
        alloc_valid = 1'b0;
        wen = 1'b1; waddr = 5'd3; wdata = 32'hA;
        set_raddr(5'd3, 5'd7);
`ifdef SCOREBOARD_RF_BYPASS_EN
        chk("byp_rdata_same", 64'(rdata[31:0]), 64'hA);
        chk("byp_rbusy_same", 64'(rbusy[0]), 64'd0);
`else
        chk("nobyp_rdata_same", 64'(rdata[31:0]), 64'd0);
        chk("nobyp_rbusy_same", 64'(rbusy[0]), 64'd1);
`endif
        chk("wb3_count_before", 64'(busy_count), 64'd1);
        tick();
        wen = 1'b0;
        #1;
        chk("wb3_rdata_next", 64'(rdata[31:0]), 64'hA);
        chk("wb3_rbusy_next", 64'(rbusy[0]), 64'd0);
        chk("wb3_count_next", 64'(busy_count), 64'd0);

        // Allocate x1, x2, x3
        alloc_valid = 1'b1;
        alloc_addr = 5'd1; tick();
        alloc_addr = 5'd2; tick();
        alloc_addr = 5'd3; tick();
        alloc_valid = 1'b0;
        #1;
        chk("alloc3_count", 64'(busy_count), 64'd3);

        // Flush with alloc x4 and a data write to x10
        flush = 1'b1; alloc_valid = 1'b1; alloc_addr = 5'd4;
        wen = 1'b1; waddr = 5'd10; wdata = 32'h99;
        #1;
        chk("flush_alloc_ready", 64'(alloc_ready), 64'd0);
        tick();
        flush = 1'b0; alloc_valid = 1'b0; wen = 1'b0;
        set_raddr(5'd4, 5'd1);
        chk("flush_count", 64'(busy_count), 64'd0);
        chk("flush_idle", 64'(idle), 64'd1);
        chk("flush_x4_busy", 64'(rbusy[0]), 64'd0);
        chk("flush_x1_busy", 64'(rbusy[1]), 64'd0);
        set_raddr(5'd10, 5'd2);
        chk("flush_x10_data", 64'(rdata[31:0]), 64'h99);
        chk("flush_x2_busy", 64'(rbusy[1]), 64'd0);

        // Alloc + writeback to free x9 in one cycle: ends busy, data written
        alloc_valid = 1'b1; alloc_addr = 5'd9;
        wen = 1'b1; waddr = 5'd9; wdata = 32'h33;
        tick();
        alloc_valid = 1'b0; wen = 1'b0;
        set_raddr(5'd9, 5'd11);
        chk("same_x9_busy", 64'(rbusy[0]), 64'd1);
        chk("same_x9_data", 64'(rdata[31:0]), 64'h33);
        chk("same_count", 64'(busy_count), 64'd1);

        // Alloc x11 while clearing x9: net count unchanged
        alloc_valid = 1'b1; alloc_addr = 5'd11;
        wen = 1'b1; waddr = 5'd9; wdata = 32'h44;
        tick();
        alloc_valid = 1'b0; wen = 1'b0;
        #1;
        chk("net0_count", 64'(busy_count), 64'd1);
        chk("net0_x9_busy", 64'(rbusy[0]), 64'd0);
        chk("net0_x11_busy", 64'(rbusy[1]), 64'd1);
        chk("net0_x9_data", 64'(rdata[31:0]), 64'h44);

        // Reset mid-flight with competing write and alloc
        rst = 1'b1; wen = 1'b1; waddr = 5'd9; wdata = 32'h77;
        alloc_valid = 1'b1; alloc_addr = 5'd12;
        tick();
        rst = 1'b0; wen = 1'b0; alloc_valid = 1'b0;
        set_raddr(5'd9, 5'd5);
        chk("rst2_x9_data", 64'(rdata[31:0]), 64'd0);
        chk("rst2_x5_data", 64'(rdata[63:32]), 64'd0);
        chk("rst2_rbusy", 64'(rbusy), 64'd0);
        chk("rst2_count", 64'(busy_count), 64'd0);
        chk("rst2_idle", 64'(idle), 64'd1);
        set_raddr(5'd12, 5'd11);
        chk("rst2_x12_x11_busy", 64'(rbusy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ysyx_23060061_scoreboard_regfile

// File: doc/ysyx_23060061_scoreboard_regfile.md
# ysyx_23060061_scoreboard_regfile

Multi-read-port integer register file with a built-in busy-bit scoreboard for the pipelined NPC core. Decode allocates a destination register on issue, which marks it busy. Writeback clears the busy bit and updates the data. Read ports return data plus a per-port busy flag, so the hazard unit stalls on RAW/WAW conditions without keeping its own table. Replaces the single-issue two-read-port register file; x0 stays hardwired to zero.

## Interface
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 32, register width
- NR_RPORTS, 2, number of read ports (1..4)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- wen  in  1  writeback valid
- waddr  in  ADDR_WIDTH  writeback index
- wdata  in  DATA_WIDTH  writeback data
- alloc_valid  in  1  issue requests destination allocation
- alloc_addr  in  ADDR_WIDTH  destination index
- alloc_ready  out  1  allocation accepted this cycle
- flush  in  1  pipeline flush; clears every busy bit
- raddr  in  NR_RPORTS*ADDR_WIDTH  packed read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rdata  out  NR_RPORTS*DATA_WIDTH  packed read data, combinational
- rbusy  out  NR_RPORTS  per-port busy flag, combinational
- busy_count  out  ADDR_WIDTH+1  number of busy registers
- idle  out  1  busy_count == 0

## Operation
- Data write: on posedge, if wen and waddr != 0, rf[waddr] <= wdata. The write happens whether or not the register is busy. x0 is never written and always reads 0.
- Allocation handshake: alloc_ready = !flush && (alloc_addr == 0 || !busy[alloc_addr]). Ready uses registered busy state only; a writeback in the same cycle does not raise it.
- Accepted allocation (alloc_valid && alloc_ready) to a nonzero index sets busy[alloc_addr]. Allocation of x0 is accepted and has no effect.
- Writeback with wen to a busy nonzero register clears its busy bit.
- Simultaneous allocation and writeback to the same index: the allocation can only be accepted if the register is not busy. The register ends busy and the data is written.
- flush: all busy bits go to 0 and busy_count goes to 0 next cycle. Data writes in the flush cycle still occur.
- busy_count: +1 on an accepted nonzero allocation, −1 on a busy-clearing writeback, net 0 when both occur. It is always equal to the popcount of busy.
- rbusy[i] = busy[raddr_i] for nonzero raddr_i; always 0 for x0.
- Reset: all rf entries 0, all busy bits 0, busy_count 0. Outputs after reset: rdata 0, rbusy 0, alloc_ready 1 (flush low), idle 1. Reset takes priority over wen, alloc, and flush in the same cycle.

## Timing
- Read latency: 0 cycles (combinational from raddr and state).
- Write/alloc/flush effects are visible from the cycle after the posedge.
- Same-cycle write-to-read behaviour depends on BYPASS_EN (see Configuration).
- busy_count and idle are registered; both reflect state after the last edge.

## Configuration
- SCOREBOARD_RF_BYPASS_EN defined: for each port, if wen && waddr == raddr_i && raddr_i != 0, then rdata_i = wdata and rbusy_i = 0 in that same cycle. This is a write-through bypass.
- Not defined: reads return the stored value and the registered busy bit. The new value and cleared busy bit appear one cycle after the writeback.
- The macro affects only the read path; alloc_ready is identical in both builds.

## Structure
- Shared package ysyx_23060061_rf_pkg holds the default ADDR_WIDTH/DATA_WIDTH constants, the x0 index constant, and the max NR_RPORTS.
- Sub-module ysyx_23060061_busy_table holds the busy bit vector, busy_count, and alloc_ready logic. Inputs: alloc, writeback-clear, and flush. Outputs: busy vector and count.
- The top level holds the data array, the read muxes, and the bypass.

## Test plan
- Reset then read all 32 indices on both ports → rdata 0, rbusy 0, alloc_ready 1, idle 1, busy_count 0.
- Write x5=0xDEADBEEF, x0=0x1234 → next cycle x5 reads 0xDEADBEEF, x0 reads 0.
- Alloc x7 and accept → rbusy 1 for x7, busy_count 1. Alloc x7 again → alloc_ready 0. Writeback x7=0x55 → busy cleared, busy_count 0, data 0x55.
- Writeback x3=0xA with raddr0=3 in the same cycle → with SCOREBOARD_RF_BYPASS_EN, rdata0=0xA that cycle; without it, old value that cycle and 0xA next cycle.
- Alloc x1, x2, x3 → busy_count 3. Flush plus alloc x4 in the same cycle → alloc_ready 0, busy_count 0, x4 not busy.
- Alloc x9, assert rst mid-flight with wen x9=0x77 in the same cycle → rf[9]=0, busy_count 0, rbusy 0.
